// File: rtl/bus_arbiter_rr.sv
// Round-robin N-to-1 arbiter for the shared system bus with a registered grant,
// an atomic lock that keeps the owner across LR/SC/AMO sequences, and an ack watchdog.
module bus_arbiter_rr #(
  parameter int N_MASTERS = 4,
  parameter int ID_W      = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_MASTERS-1:0]   i_bus_en,
  input  logic [N_MASTERS-1:0]   i_wr_rd,
  input  logic [32*N_MASTERS-1:0] i_wr_data,
  input  logic [32*N_MASTERS-1:0] i_addr,
  input  logic [4*N_MASTERS-1:0] i_byte_en,
  input  logic [N_MASTERS-1:0]   i_atomic,
  input  logic [7*N_MASTERS-1:0] i_operation,
  output logic [N_MASTERS-1:0]   o_ack,
  output logic [N_MASTERS-1:0]   o_err,
  output logic [32*N_MASTERS-1:0] o_rd_data,
  input  logic                   i_ack,
  input  logic [31:0]            i_rd_data,
  output logic [ID_W-1:0]        o_id,
  output logic                   o_bus_en,
  output logic                   o_wr_en,
  output logic [31:0]            o_wr_data,
  output logic [31:0]            o_addr,
  output logic [3:0]             o_byte_en,
  output logic                   o_atomic,
  output logic [6:0]             o_operation,
  output logic                   o_busy
);

  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   owner_reg, owner_next;
  logic [ID_W-1:0]   last_reg, last_next;
  logic [WDOG_W-1:0] wdog_reg, wdog_next;

  logic [31:0] wr_data_arr [N_MASTERS];
  logic [31:0] addr_arr    [N_MASTERS];
  logic [3:0]  byte_en_arr [N_MASTERS];
  logic [6:0]  op_arr      [N_MASTERS];

  logic [ID_W-1:0]      rot_idx [N_MASTERS];
  logic [N_MASTERS-1:0] rot_req;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_any;

  logic owner_req;
  logic owner_atomic;
  logic bus_active;
  logic timeout_hit;

  // rot_req[k] is the request of the master k+1 positions after the last owner
  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_rot
      logic [ID_W:0] sum;
      assign sum = {1'b0, last_reg} + (ID_W+1)'(gi + 1);
      assign rot_idx[gi] = (sum >= (ID_W+1)'(N_MASTERS)) ?
                           ID_W'(sum - (ID_W+1)'(N_MASTERS)) : sum[ID_W-1:0];
      assign rot_req[gi] = i_bus_en[rot_idx[gi]];

      assign wr_data_arr[gi] = i_wr_data[32*gi +: 32];
      assign addr_arr[gi]    = i_addr[32*gi +: 32];
      assign byte_en_arr[gi] = i_byte_en[4*gi +: 4];
      assign op_arr[gi]      = i_operation[7*gi +: 7];
    end
  endgenerate

  assign grant_any = |rot_req;

  always_comb begin
    grant_idx = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (rot_req[k]) grant_idx = rot_idx[k];
    end
  end

  assign owner_req    = i_bus_en[owner_reg];
  assign owner_atomic = i_atomic[owner_reg];
  assign bus_active   = (state_reg == BUSY) || (state_reg == LOCK);

  // An owner that withdraws its request aborts silently, even on the timeout cycle
  assign timeout_hit = (TIMEOUT != 0) && (state_reg == BUSY) && !i_ack && owner_req &&
                       (wdog_reg == WDOG_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      last_reg  <= ID_W'(N_MASTERS - 1);
      wdog_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      wdog_reg  <= wdog_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    wdog_next  = wdog_reg;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          owner_next = grant_idx;
          wdog_next  = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (i_ack) begin
          last_next  = owner_reg;
          state_next = owner_atomic ? LOCK : IDLE;
        end else if (!owner_req || timeout_hit) begin
          last_next  = owner_reg;
          state_next = IDLE;
        end else begin
          wdog_next = wdog_reg + WDOG_W'(1);
        end
      end
      LOCK: begin
        if (owner_req) begin
          wdog_next  = '0;
          state_next = BUSY;
        end else if (!owner_atomic) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_id        = '0;
    o_wr_en     = 1'b0;
    o_wr_data   = '0;
    o_addr      = '0;
    o_byte_en   = '0;
    o_atomic    = 1'b0;
    o_operation = '0;
    if (bus_active) begin
      o_id        = owner_reg;
      o_wr_en     = i_wr_rd[owner_reg];
      o_wr_data   = wr_data_arr[owner_reg];
      o_addr      = addr_arr[owner_reg];
      o_byte_en   = byte_en_arr[owner_reg];
      o_atomic    = owner_atomic;
      o_operation = op_arr[owner_reg];
    end
  end

  assign o_bus_en = (state_reg == BUSY) && owner_req && !i_ack;
  assign o_busy   = (state_reg != IDLE);

  // Return path is combinational so the owner sees ack/data in the bus ack cycle
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_ret
      logic is_owner;
      assign is_owner = (state_reg == BUSY) && (owner_reg == ID_W'(gi));
      assign o_ack[gi]              = is_owner && (i_ack || timeout_hit);
      assign o_err[gi]              = is_owner && timeout_hit;
      assign o_rd_data[32*gi +: 32] = is_owner ? i_rd_data : 32'h0;
    end
  endgenerate

endmodule
